// File: rtl/apb_master.sv
// APB requester: accepts single read/write requests over valid/ready, runs the
// APB SETUP/ACCESS protocol toward a UART/TIMER select mux, and returns a
// one-cycle response pulse. Every transfer is bounded by a PREADY timeout, and
// addresses in the upper two regions are rejected without touching the bus.
module apb_master #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  // request side
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  // response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  // APB side
  output logic                  PSEL_UART,
  output logic                  PSEL_TIMER,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PENABLE,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] REGION_UART  = 2'b00;
  localparam logic [1:0] REGION_TIMER = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    tmo_q, tmo_d;

  logic [1:0]              region;
  logic                    in_xfer;

  // The region is taken from the latched address so the select stays
  // consistent with PADDR for the whole SETUP/ACCESS window.
  assign region  = paddr_q[ADDR_WIDTH-1:ADDR_WIDTH-2];
  assign in_xfer = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

  // Next-state, address/data latching and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          if (req_write) begin
            pwdata_d = req_wdata;
          end
          if (req_addr[ADDR_WIDTH-1]) begin
            // Regions 10/11 have no slave: answer immediately with an error.
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b0;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        // PREADY is tested first so a slave that answers on the last allowed
        // cycle still gets a normal response.
        if (PREADY) begin
          rdata_d = (pwrite_q || PSLVERR) ? '0 : PRDATA;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset drops any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;

  assign PSEL_UART   = in_xfer && (region == REGION_UART);
  assign PSEL_TIMER  = in_xfer && (region == REGION_TIMER);
  assign PENABLE     = (state_q == ST_ACCESS);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PWDATA      = pwdata_q;

  // Protocol invariants seen by the select mux.
  a_sel_onehot : assert property (@(posedge PCLK) disable iff (!PRESETn)
    !(PSEL_UART && PSEL_TIMER));

  a_enable_has_sel : assert property (@(posedge PCLK) disable iff (!PRESETn)
    PENABLE |-> (PSEL_UART || PSEL_TIMER));

  a_rsp_single : assert property (@(posedge PCLK) disable iff (!PRESETn)
    rsp_valid |=> !rsp_valid);

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: a transaction-level model predicts every
// output cycle by cycle from the request, the scripted slave wait count and
// the protocol timing; literal checks pin latencies and response values.
module tb_apb_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TC = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL_UART;
  logic          PSEL_TIMER;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PENABLE;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL_UART  (PSEL_UART),
    .PSEL_TIMER (PSEL_TIMER),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PENABLE    (PENABLE),
    .PREADY     (PREADY),
    .PRDATA     (PRDATA),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Current transaction as issued by the driver; slave behaviour is scripted
  // from it: PREADY rises on ACCESS cycle (m_w+1), never within the window if
  // m_w >= TC.
  logic          m_active = 1'b0;
  int            m_t0 = 0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  int            m_w = 0;
  logic [DW-1:0] m_rd = '0;
  logic          m_se = 1'b0;

  // Values the outputs must be holding.
  logic [AW-1:0] m_paddr = '0;
  logic          m_pwrite = 1'b0;
  logic [DW-1:0] m_pwdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic          m_tmo = 1'b0;

  assign PREADY  = m_active && (cyc >= (m_t0 + 2 + m_w));
  assign PRDATA  = m_rd;
  assign PSLVERR = m_se;

  // Observations for the per-test literal checks.
  int obs_uart = 0, obs_timer = 0, obs_pen = 0, obs_rsp_n = 0, obs_rsp_cyc = -1;

  int   rel, nacc, endc;
  logic dec, tmo, busy, e_setup, e_access, e_resp, e_uart, e_timer;

  // Cycle-by-cycle comparison against the transaction model.
  always @(negedge PCLK) begin
    if (PRESETn) begin
      rel      = cyc - m_t0;
      dec      = m_addr[AW-1];
      tmo      = (m_w >= TC);
      nacc     = tmo ? TC : m_w + 1;
      endc     = dec ? 1 : nacc + 2;
      busy     = m_active && (rel >= 1) && (rel <= endc);
      e_resp   = busy && (rel == endc);
      e_setup  = busy && !dec && (rel == 1);
      e_access = busy && !dec && (rel >= 2) && (rel < endc);
      if (busy && rel == 1) begin
        m_paddr  = m_addr;
        m_pwrite = m_wr;
        if (m_wr) m_pwdata = m_wd;
      end
      if (e_resp) begin
        m_rdata = (dec || tmo || m_wr || m_se) ? '0 : m_rd;
        m_err   = dec || tmo || m_se;
        m_tmo   = tmo;
      end
      e_uart  = (e_setup || e_access) && (m_addr[AW-1:AW-2] == 2'b00);
      e_timer = (e_setup || e_access) && (m_addr[AW-1:AW-2] == 2'b01);

      check("req_ready",   64'(req_ready),   64'(!busy));
      check("rsp_valid",   64'(rsp_valid),   64'(e_resp));
      check("rsp_rdata",   64'(rsp_rdata),   64'(m_rdata));
      check("rsp_err",     64'(rsp_err),     64'(m_err));
      check("rsp_timeout", 64'(rsp_timeout), 64'(m_tmo));
      check("PSEL_UART",   64'(PSEL_UART),   64'(e_uart));
      check("PSEL_TIMER",  64'(PSEL_TIMER),  64'(e_timer));
      check("PENABLE",     64'(PENABLE),     64'(e_access));
      check("PADDR",       64'(PADDR),       64'(m_paddr));
      check("PWRITE",      64'(PWRITE),      64'(m_pwrite));
      check("PWDATA",      64'(PWDATA),      64'(m_pwdata));

      if (PSEL_UART)  obs_uart  = obs_uart + 1;
      if (PSEL_TIMER) obs_timer = obs_timer + 1;
      if (PENABLE)    obs_pen   = obs_pen + 1;
      if (rsp_valid) begin
        obs_rsp_n   = obs_rsp_n + 1;
        obs_rsp_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic clear_obs();
    obs_uart = 0; obs_timer = 0; obs_pen = 0; obs_rsp_n = 0; obs_rsp_cyc = -1;
  endtask

  task automatic start_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int w, input logic [DW-1:0] rd, input logic se);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    m_t0 = cyc; m_wr = wr; m_addr = addr; m_wd = wd; m_w = w; m_rd = rd; m_se = se;
    m_active = 1'b1;
    clear_obs();
    tick();
    // Scramble the request bus so held APB values are really held.
    req_valid = 1'b0; req_write = ~wr; req_addr = ~addr; req_wdata = ~wd;
  endtask

  // Issue one request and return in the first IDLE cycle after its response.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input int w, input logic [DW-1:0] rd, input logic se);
    int last;
    if (addr[AW-1]) last = 1;
    else if (w >= TC) last = TC + 2;
    else last = w + 3;
    start_req(wr, addr, wd, w, rd, se);
    while (cyc <= m_t0 + last) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_rsp",   64'(rsp_valid), 64'd0);
    check("reset_sel",   64'({PSEL_UART, PSEL_TIMER, PENABLE}), 64'd0);
    check("reset_paddr", 64'(PADDR), 64'd0);
    PRESETn = 1'b1;
    repeat (2) tick();

    // Zero-wait UART write.
    do_txn(1'b1, 10'h004, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    check("t1_latency", 64'(obs_rsp_cyc - m_t0), 64'd3);
    check("t1_uart",    64'(obs_uart), 64'd2);
    check("t1_pen",     64'(obs_pen), 64'd1);
    check("t1_err",     64'(rsp_err), 64'd0);
    check("t1_pwdata",  64'(PWDATA), 64'hDEADBEEF);

    // Timer read, three wait states.
    do_txn(1'b0, 10'h108, 32'h0, 3, 32'h12345678, 1'b0);
    check("t2_latency", 64'(obs_rsp_cyc - m_t0), 64'd6);
    check("t2_timer",   64'(obs_timer), 64'd5);
    check("t2_uart",    64'(obs_uart), 64'd0);
    check("t2_rdata",   64'(rsp_rdata), 64'h12345678);

    // UART read with slave error.
    do_txn(1'b0, 10'h020, 32'h0, 1, 32'h0, 1'b1);
    check("t3_err", 64'({rsp_err, rsp_timeout}), 64'b10);
    check("t3_latency", 64'(obs_rsp_cyc - m_t0), 64'd4);

    // Decode error, region 10.
    do_txn(1'b0, 10'h2A0, 32'h0, 0, 32'h55555555, 1'b0);
    check("t4_latency", 64'(obs_rsp_cyc - m_t0), 64'd1);
    check("t4_bus",     64'(obs_uart + obs_timer + obs_pen), 64'd0);
    check("t4_resp",    64'({rsp_err, rsp_timeout}), 64'b10);
    check("t4_rdata",   64'(rsp_rdata), 64'd0);

    // PREADY never rises: timeout after 16 ACCESS cycles.
    do_txn(1'b0, 10'h0F0, 32'h0, 100, 32'h99999999, 1'b0);
    check("t5_latency", 64'(obs_rsp_cyc - m_t0), 64'd18);
    check("t5_pen",     64'(obs_pen), 64'd16);
    check("t5_resp",    64'({rsp_err, rsp_timeout}), 64'b11);
    check("t5_rdata",   64'(rsp_rdata), 64'd0);

    // PREADY rises on the 16th ACCESS cycle: normal response.
    do_txn(1'b0, 10'h1FC, 32'h0, 15, 32'hA5A50F0F, 1'b0);
    check("t6_latency", 64'(obs_rsp_cyc - m_t0), 64'd18);
    check("t6_resp",    64'({rsp_err, rsp_timeout}), 64'b00);
    check("t6_rdata",   64'(rsp_rdata), 64'hA5A50F0F);

    // Timer write with slave error, then decode error in region 11.
    do_txn(1'b1, 10'h104, 32'h0BADF00D, 2, 32'h77777777, 1'b1);
    check("t7_resp",  64'({rsp_err, rsp_timeout}), 64'b10);
    check("t7_rdata", 64'(rsp_rdata), 64'd0);
    do_txn(1'b1, 10'h3FF, 32'h13572468, 0, 32'h0, 1'b0);
    check("t8_latency", 64'(obs_rsp_cyc - m_t0), 64'd1);
    check("t8_pwdata",  64'(PWDATA), 64'h13572468);
    repeat (3) tick();

    // Reset during the second ACCESS cycle.
    start_req(1'b0, 10'h010, 32'h0, 5, 32'h11112222, 1'b0);
    repeat (2) tick();
    check("rst_pre_pen", 64'(PENABLE), 64'd1);
    #2;
    PRESETn = 1'b0;
    m_active = 1'b0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0; m_err = 1'b0; m_tmo = 1'b0;
    #1;
    check("rst_sel",   64'({PSEL_UART, PSEL_TIMER, PENABLE}), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_rsp",   64'(rsp_valid), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    tick(); tick();
    #2;
    PRESETn = 1'b1;
    clear_obs();
    repeat (6) tick();
    check("rst_no_rsp",    64'(obs_rsp_n), 64'd0);
    check("rst_ready_rel", 64'(req_ready), 64'd1);

    // Normal operation after reset.
    do_txn(1'b0, 10'h0C8, 32'h0, 0, 32'h0BADCAFE, 1'b0);
    check("t10_latency", 64'(obs_rsp_cyc - m_t0), 64'd3);
    check("t10_rdata",   64'(rsp_rdata), 64'h0BADCAFE);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
